// File: rtl/load_access_ctrl.sv
// RV32I load sequencer: word-aligned read(s) over req/gnt/rvalid, lane select and sign/zero extension. Optional MISALIGNED_SPLIT_EN splits misaligned loads into two word reads.
// Latency: ld_done 3 cycles after accept (5 when split); illegal/misaligned ld_err after 1.
// Backpressure: ld_ready low while busy, ld_req then ignored; mem_req held until mem_gnt.
module load_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  output logic        ld_ready,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  byte_sel,
  output logic [31:0] ld_data,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_REQ2, S_WAIT2, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
`endif

  state_t          state_q, state_d;
  logic [2:0]      funct3_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic            accept, bad_req, misal, in_wait, timeout, take_data, last_word;
  logic [4:0]      sh;
  logic [31:0]     lane_word;
`ifdef MISALIGNED_SPLIT_EN
  logic            split_q;
  logic [31:0]     w0_q;
`endif

  function automatic logic legal_f3(input logic [2:0] f3);
    legal_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b100:  extend = {24'h0, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b101:  extend = {16'h0, w[15:0]};
      3'b010:  extend = w;
      default: extend = 32'h0;
    endcase
  endfunction

  assign misal = ((ld_funct3[1:0] == 2'b01) && ld_addr[0]) ||
                 ((ld_funct3[1:0] == 2'b10) && (ld_addr[1:0] != 2'b00));
  assign sh    = {byte_sel, 3'b000};

  // Lane extraction: the wanted bytes are shifted down to bit 0 before extension.
`ifdef MISALIGNED_SPLIT_EN
  assign lane_word = (state_q == S_WAIT2) ? 32'({mem_rdata, w0_q} >> sh) : (mem_rdata >> sh);
  assign in_wait   = (state_q == S_WAIT) || (state_q == S_WAIT2);
  assign last_word = (state_q == S_WAIT2) || !split_q;
`else
  assign lane_word = mem_rdata >> sh;
  assign in_wait   = (state_q == S_WAIT);
  assign last_word = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    mem_req   = 1'b0;
    ld_done   = 1'b0;
    ld_err    = 1'b0;
    accept    = 1'b0;
    bad_req   = 1'b0;
    timeout   = 1'b0;
    take_data = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_req) begin
          accept = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
          bad_req = !legal_f3(ld_funct3);
`else
          bad_req = !legal_f3(ld_funct3) || misal;
`endif
          state_d = bad_req ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        if (mem_rvalid) begin
          take_data = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
          state_d = split_q ? S_REQ2 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end else if (timeout) begin
          state_d = S_RESP;
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      S_REQ2: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        if (mem_rvalid) begin
          take_data = 1'b1;
          state_d   = S_RESP;
        end else if (timeout) begin
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        ld_done = !err_q;
        ld_err  = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'b000;
      byte_sel <= 2'b00;
      mem_addr <= 32'h0;
      err_q    <= 1'b0;
      ld_data  <= 32'h0;
      cnt_q    <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q  <= 1'b0;
      w0_q     <= 32'h0;
`endif
    end else begin
      // Counter runs only while waiting, so every entry to a wait state starts from zero.
      cnt_q <= in_wait ? cnt_q + CW'(1) : '0;
      if (accept) begin
        funct3_q <= ld_funct3;
        byte_sel <= ld_addr[1:0];
        mem_addr <= {ld_addr[31:2], 2'b00};
        err_q    <= bad_req;
        ld_data  <= 32'h0;
`ifdef MISALIGNED_SPLIT_EN
        split_q  <= misal;
`endif
      end
      if (take_data) begin
        if (last_word) begin
          ld_data <= extend(funct3_q, lane_word);
        end else begin
`ifdef MISALIGNED_SPLIT_EN
          w0_q     <= mem_rdata;
          mem_addr <= mem_addr + 32'd4;
`endif
        end
      end else if (in_wait && timeout) begin
        err_q   <= 1'b1;
        ld_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_load_access_ctrl.sv
// Directed bench for load_access_ctrl: table of loads against a two-word memory, error, timeout and reset cases.
module tb_load_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req;
  logic        ld_ready;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  byte_sel;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  load_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_ready(ld_ready), .ld_funct3(ld_funct3), .ld_addr(ld_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .byte_sel(byte_sel), .ld_data(ld_data), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'hABCD_EF17;
      32'h0000_0104: mem_word = 32'h0123_4567;
      32'hFFFF_FFFC: mem_word = 32'h1122_3344;
      32'h0000_0000: mem_word = 32'h5566_7788;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load with a responder that grants immediately and returns data rv_delay
  // cycles into the wait (negative: never). Latency is counted to the edge that samples ld_done/ld_err.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int rv_delay,
                         input logic hold_req,
                         output logic [31:0] data, output logic err, output int lat,
                         output logic req_seen, output logic [31:0] addr1,
                         output logic [31:0] addr2, output logic [1:0] sel);
    int          t_acc, rv_cnt;
    logic        pend, fin, got1;
    logic [31:0] paddr;
    ld_req = 1'b1; ld_funct3 = f3; ld_addr = a;
    @(posedge clk); #1;
    t_acc = cyc;
    if (!hold_req) ld_req = 1'b0;
    pend = 1'b0; fin = 1'b0; got1 = 1'b0; req_seen = 1'b0; rv_cnt = 0;
    paddr = 32'h0; addr1 = 32'hX; addr2 = 32'hX; data = 32'hX; err = 1'bX; lat = -1; sel = 2'bXX;
    for (int i = 0; i < 64 && !fin; i++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (ld_done || ld_err) begin
        data = ld_data; err = ld_err; sel = byte_sel;
        lat = cyc + 1 - t_acc;
        fin = 1'b1; ld_req = 1'b0;
      end else begin
        if (pend) begin
          if (rv_cnt == rv_delay) begin
            mem_rvalid = 1'b1; mem_rdata = mem_word(paddr); pend = 1'b0;
          end
          rv_cnt++;
        end
        if (mem_req) begin
          req_seen = 1'b1; mem_gnt = 1'b1; paddr = mem_addr; pend = 1'b1; rv_cnt = 0;
          if (!got1) begin addr1 = mem_addr; got1 = 1'b1; end
          else addr2 = mem_addr;
        end
        @(posedge clk); #1;
      end
    end
    chk("load_finished", {31'h0, fin}, 32'h1);
    @(posedge clk); #1;
  endtask

  logic [31:0] d, a1, a2;
  logic        e, rq;
  int          lt;
  logic [1:0]  bs;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld_req = 1'b0; ld_funct3 = 3'b000; ld_addr = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ld_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_done_err", {30'h0, ld_done, ld_err}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_byte_sel", {30'h0, byte_sel}, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(3'b000, 32'h100, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lb100_data", d, 32'h0000_0017);
    chk("lb100_sel", {30'h0, bs}, 32'h0);
    chk("lb100_err", {31'h0, e}, 32'h0);
    chk("lb100_lat", lt, 32'd3);
    chk("lb100_addr", a1, 32'h100);

    do_load(3'b000, 32'h102, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lb102_data", d, 32'hFFFF_FFCD);
    chk("lb102_sel", {30'h0, bs}, 32'h2);
    chk("lb102_addr", a1, 32'h100);
    do_load(3'b100, 32'h103, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lbu103_data", d, 32'h0000_00AB);
    do_load(3'b001, 32'h102, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lh102_data", d, 32'hFFFF_ABCD);
    do_load(3'b101, 32'h100, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lhu100_data", d, 32'h0000_EF17);
    do_load(3'b010, 32'h104, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lw104_data", d, 32'h0123_4567);
    chk("lw104_addr", a1, 32'h104);

    // ld_req held high through the whole load must not start a second one.
    do_load(3'b010, 32'h100, 0, 1'b1, d, e, lt, rq, a1, a2, bs);
    chk("lw100_data", d, 32'hABCD_EF17);
    chk("lw100_lat", lt, 32'd3);
    chk("noqueue_ready", {31'h0, ld_ready}, 32'h1);
    @(posedge clk); #1;
    chk("noqueue_mem_req", {30'h0, mem_req, ld_ready}, 32'h1);

`ifdef MISALIGNED_SPLIT_EN
    do_load(3'b101, 32'h101, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lhu101_split_data", d, 32'h0000_CDEF);
    chk("lhu101_split_lat", lt, 32'd5);
    do_load(3'b010, 32'h103, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lw103_data", d, 32'h2345_67AB);
    chk("lw103_addr2", a2, 32'h104);
    chk("lw103_lat", lt, 32'd5);
    do_load(3'b001, 32'h103, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lh103_data", d, 32'h0000_67AB);
    do_load(3'b101, 32'hFFFF_FFFF, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("wrap_addr1", a1, 32'hFFFF_FFFC);
    chk("wrap_addr2", a2, 32'h0000_0000);
    chk("wrap_data", d, 32'h0000_8811);
`else
    do_load(3'b101, 32'h101, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lhu101_err", {31'h0, e}, 32'h1);
    chk("lhu101_lat", lt, 32'd1);
    chk("lhu101_noreq", {31'h0, rq}, 32'h0);
    chk("lhu101_data", d, 32'h0);
    do_load(3'b010, 32'h102, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("lw102_err", {30'h0, e, rq}, 32'h2);
`endif

    do_load(3'b011, 32'h100, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("f3_011_err", {31'h0, e}, 32'h1);
    chk("f3_011_data", d, 32'h0);
    chk("f3_011_noreq", {31'h0, rq}, 32'h0);
    do_load(3'b000, 32'h100, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("after_err_lb100", d, 32'h0000_0017);

    do_load(3'b010, 32'h104, -1, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("tmo_err", {31'h0, e}, 32'h1);
    chk("tmo_data", d, 32'h0);
    chk("tmo_lat", lt, 32'd18);
    do_load(3'b010, 32'h104, 15, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("tmo_edge_err", {31'h0, e}, 32'h0);
    chk("tmo_edge_data", d, 32'h0123_4567);
    chk("tmo_edge_lat", lt, 32'd18);

    // Reset while waiting for read data, then a stale rvalid arrives.
    ld_req = 1'b1; ld_funct3 = 3'b000; ld_addr = 32'h101;
    @(posedge clk); #1;
    ld_req = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ld_ready}, 32'h1);
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_byte_sel", {30'h0, byte_sel}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_EF17;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_quiet", {29'h0, ld_done, ld_err, ld_ready}, 32'h1);
    @(posedge clk); #1;
    chk("late_rvalid_quiet2", {29'h0, ld_done, ld_err, ld_ready}, 32'h1);
    do_load(3'b000, 32'h101, 0, 1'b0, d, e, lt, rq, a1, a2, bs);
    chk("post_rst_lb101", d, 32'hFFFF_FFEF);
    chk("post_rst_sel", {30'h0, bs}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
